// File: rtl/fb_scanout.sv
// fb_scanout: read side of the dual-bank framebuffer plus raster timing.
// Generates the pixel tick and the h/v counters, fetches each active pixel
// through a 1-clk-latency read port, and drives colour/sync two clocks after
// the tick. The bank swap with the writer is sampled only at the start of the
// first blank line, so the displayed bank never changes mid-frame.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 4,
  parameter int SYNC_POL = 0,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [5:0]        rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_bank,
  output logic              frame_start,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare bit so the sync end bound still fits when the back porch is 0.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  // Bank 1 starts right after one full frame; a constant, no runtime multiply.
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = (SYNC_POL == 0);

  // timing / fetch stage state
  logic [DW-1:0]     div_q, div_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic              bank_q, bank_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              ack_q, ack_d;
  logic              fs_q, fs_d;
  logic              act1_q, act1_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;

  // delay stage aligned with RAM latency, and output stage
  logic              t1_q, t2_q;
  logic              act2_q, hs2_q, vs2_q;
  logic [3:0]        r_q, g_q, b_q;
  logic              hs_q, vs_q;

  logic              tick;
  logic              origin;
  logic              active;
  logic              hs_on;
  logic              vs_on;
  logic [ADDR_W-1:0] lin_cur;
  logic [ADDR_W-1:0] base;

  // Next-state for divider, raster counters, fetch request and swap handshake.
  always_comb begin
    tick    = (div_q == DIV_LAST);
    origin  = (h_q == '0) && (v_q == '0);
    active  = (h_q < H_ACT) && (v_q < V_ACT);
    hs_on   = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_on   = (v_q >= VS_BEG) && (v_q < VS_END);
    lin_cur = origin ? '0 : lin_q;
    base    = bank_q ? BANK1_BASE : '0;

    div_d     = tick ? '0 : div_q + 1'b1;
    h_d       = h_q;
    v_d       = v_q;
    lin_d     = lin_q;
    bank_d    = bank_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    ack_d     = 1'b0;
    fs_d      = 1'b0;
    act1_d    = act1_q;
    hs1_d     = hs1_q;
    vs1_d     = vs1_q;

    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end

      act1_d = active;
      hs1_d  = hs_on ? SYNC_ON : SYNC_OFF;
      vs1_d  = vs_on ? SYNC_ON : SYNC_OFF;
      fs_d   = origin;

      if (active) begin
        rd_en_d   = 1'b1;
        rd_addr_d = base + lin_cur;
        lin_d     = lin_cur + 1'b1;
      end else if (origin) begin
        lin_d = '0;
      end

      // Only the first blank line's opening tick may flip the displayed bank.
      if ((h_q == '0) && (v_q == V_ACT) && swap_req) begin
        bank_d = ~bank_q;
        ack_d  = 1'b1;
      end
    end
  end

  // Timing and fetch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      lin_q     <= '0;
      bank_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ack_q     <= 1'b0;
      fs_q      <= 1'b0;
      act1_q    <= 1'b0;
      hs1_q     <= SYNC_OFF;
      vs1_q     <= SYNC_OFF;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      lin_q     <= lin_d;
      bank_q    <= bank_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      ack_q     <= ack_d;
      fs_q      <= fs_d;
      act1_q    <= act1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
    end
  end

  // Carry sync/active one more clk while the RAM answers, then update colour
  // and sync together two clks after the tick, holding until the next pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      t1_q   <= 1'b0;
      t2_q   <= 1'b0;
      act2_q <= 1'b0;
      hs2_q  <= SYNC_OFF;
      vs2_q  <= SYNC_OFF;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= SYNC_OFF;
      vs_q   <= SYNC_OFF;
    end else begin
      t1_q   <= tick;
      t2_q   <= t1_q;
      act2_q <= act1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      if (t2_q) begin
        r_q  <= act2_q ? {rd_data[5:4], rd_data[5:4]} : 4'h0;
        g_q  <= act2_q ? {rd_data[3:2], rd_data[3:2]} : 4'h0;
        b_q  <= act2_q ? {rd_data[1:0], rd_data[1:0]} : 4'h0;
        hs_q <= hs2_q;
        vs_q <= vs2_q;
      end
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign swap_ack    = ack_q;
  assign front_bank  = bank_q;
  assign frame_start = fs_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout with an 8x6 raster, PIX_DIV=2 and a 1-clk RAM model
// returning rd_addr[5:0].
module tb_fb_scanout;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [5:0]    rd_data = 6'h0;
  logic          swap_req = 1'b0;
  logic          swap_ack;
  logic          front_bank;
  logic          frame_start;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs;

  fb_scanout #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(2), .SYNC_POL(0), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_bank(front_bank),
    .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= rd_addr[5:0];

  typedef struct packed {
    int         due;
    logic [3:0] r, g, b;
    logic       hs, vs;
  } out_t;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int            e = 0;
  logic          m_bank = 1'b0;
  logic          m_rd = 1'b0, m_fs = 1'b0, m_ack = 1'b0, m_swap_pt = 1'b0;
  logic [3:0]    exp_r = 4'h0, exp_g = 4'h0, exp_b = 4'h0;
  logic          exp_hs = 1'b1, exp_vs = 1'b1;
  logic [AW-1:0] addr_q[$];
  out_t          col_q[$];

  task automatic model_reset();
    e = 0; m_bank = 1'b0;
    m_rd = 1'b0; m_fs = 1'b0; m_ack = 1'b0; m_swap_pt = 1'b0;
    exp_r = 4'h0; exp_g = 4'h0; exp_b = 4'h0; exp_hs = 1'b1; exp_vs = 1'b1;
    addr_q.delete();
    col_q.delete();
  endtask

  // Advance one clk, sample 1 time unit after the edge, update the model.
  task automatic step();
    logic          req;
    int            p, h, v, bs;
    logic          act;
    logic [AW-1:0] a;
    out_t          ent;
    req = swap_req;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      return;
    end
    e++;
    m_rd = 1'b0; m_fs = 1'b0; m_ack = 1'b0; m_swap_pt = 1'b0;
    if (e % 2 == 0) begin
      p   = e / 2 - 1;
      h   = p % 8;
      v   = (p / 8) % 6;
      act = (h < 4) && (v < 3);
      a   = '0;
      if (act) begin
        bs = m_bank ? 12 : 0;
        a  = AW'(bs + v * 4 + h);
        addr_q.delete();
        addr_q.push_back(a);
        m_rd = 1'b1;
      end
      ent.due = e + 2;
      ent.r   = act ? {a[5:4], a[5:4]} : 4'h0;
      ent.g   = act ? {a[3:2], a[3:2]} : 4'h0;
      ent.b   = act ? {a[1:0], a[1:0]} : 4'h0;
      ent.hs  = !((h >= 5) && (h < 7));
      ent.vs  = !(v == 4);
      col_q.push_back(ent);
      m_fs = (h == 0) && (v == 0);
      if ((h == 0) && (v == 3)) begin
        m_swap_pt = 1'b1;
        if (req) begin
          m_bank = ~m_bank;
          m_ack  = 1'b1;
        end
      end
    end
    if ((col_q.size() > 0) && (col_q[0].due == e)) begin
      ent = col_q.pop_front();
      exp_r = ent.r; exp_g = ent.g; exp_b = ent.b;
      exp_hs = ent.hs; exp_vs = ent.vs;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    swap_req = 1'b0;
    repeat (5) step();
    n_checks++;
    if ({rd_en, rd_addr, swap_ack, frame_start, front_bank} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got en=%b addr=%h ack=%b fs=%b bank=%b, expected all 0",
               rd_en, rd_addr, swap_ack, frame_start, front_bank);
    end
    n_checks++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {12'h000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_video: got rgb=%h%h%h hs=%b vs=%b, expected rgb=000 hs=1 vs=1",
               vga_r, vga_g, vga_b, vga_hs, vga_vs);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL first_edge_rd_en: got %b expected 0", rd_en);
    end
    step();
    n_checks++;
    if ({rd_en, rd_addr, frame_start} !== {1'b1, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL first_fetch: got en=%b addr=%h fs=%b expected en=1 addr=00 fs=1",
               rd_en, rd_addr, frame_start);
    end
    addr_q.delete();
  endtask

  task automatic test_pixel_map();
    logic [AW-1:0] ea;
    while (e < 40) begin
      step();
      n_checks++;
      if ({rd_en, frame_start} !== {m_rd, m_fs}) begin
        n_fail++;
        $display("FAIL map_strobes e=%0d: got en=%b fs=%b expected en=%b fs=%b",
                 e, rd_en, frame_start, m_rd, m_fs);
      end
      if (rd_en === 1'b1) begin
        n_checks++;
        if (addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL map_addr e=%0d: got unexpected read addr=%h, expected no read", e, rd_addr);
        end else begin
          ea = addr_q.pop_front();
          if (rd_addr !== ea) begin
            n_fail++;
            $display("FAIL map_addr e=%0d: got %h expected %h", e, rd_addr, ea);
          end
        end
      end
      n_checks++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {exp_r, exp_g, exp_b, exp_hs, exp_vs}) begin
        n_fail++;
        $display("FAIL map_video e=%0d: got rgb=%h%h%h hs=%b vs=%b expected rgb=%h%h%h hs=%b vs=%b",
                 e, vga_r, vga_g, vga_b, vga_hs, vga_vs, exp_r, exp_g, exp_b, exp_hs, exp_vs);
      end
      if (e == 22) begin
        n_checks++;
        if ({rd_en, rd_addr} !== {1'b1, 8'h06}) begin
          n_fail++;
          $display("FAIL pix21_addr: got en=%b addr=%h expected en=1 addr=06", rd_en, rd_addr);
        end
      end
      if (e == 24) begin
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h05A) begin
          n_fail++;
          $display("FAIL pix21_colour: got %h%h%h expected 05A", vga_r, vga_g, vga_b);
        end
      end
      if (e == 14) begin
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
          n_fail++;
          $display("FAIL blank_colour: got %h%h%h expected 000", vga_r, vga_g, vga_b);
        end
      end
    end
  endtask

  task automatic test_swap();
    int acks = 0;
    swap_req = 1'b1;
    while (e < 98) begin
      step();
      if (swap_ack === 1'b1) acks++;
      n_checks++;
      if ({swap_ack, front_bank} !== {m_ack, m_bank}) begin
        n_fail++;
        $display("FAIL swap_track e=%0d: got ack=%b bank=%b expected ack=%b bank=%b",
                 e, swap_ack, front_bank, m_ack, m_bank);
      end
      if (e == 50) begin
        n_checks++;
        if ({swap_ack, front_bank} !== 2'b11) begin
          n_fail++;
          $display("FAIL swap_point: got ack=%b bank=%b expected ack=1 bank=1", swap_ack, front_bank);
        end
      end
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL swap_ack_count: got %0d expected 1", acks);
    end
    n_checks++;
    if ({rd_en, rd_addr} !== {1'b1, 8'h0C}) begin
      n_fail++;
      $display("FAIL frame1_first_addr: got en=%b addr=%h expected en=1 addr=0c", rd_en, rd_addr);
    end
    swap_req = 1'b0;
    acks = 0;
    while (e < 150) begin
      step();
      if (swap_ack === 1'b1) acks++;
      n_checks++;
      if (front_bank !== 1'b1) begin
        n_fail++;
        $display("FAIL swap_hold e=%0d: got bank=%b expected 1", e, front_bank);
      end
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL swap_no_ack: got %0d acks expected 0", acks);
    end
  endtask

  task automatic test_sync();
    int   hs_lo = 0, vs_lo = 0, fs_early = 0;
    int   first_hs = -1, first_vs = -1;
    logic found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (frame_start === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL sync_wait_frame: got no frame_start in 200 clk, expected one");
      return;
    end
    for (int o = 1; o <= 96; o++) begin
      step();
      if (vga_hs === 1'b0) begin
        hs_lo++;
        if (first_hs < 0) first_hs = o;
      end
      if (vga_vs === 1'b0) begin
        vs_lo++;
        if (first_vs < 0) first_vs = o;
      end
      if ((o < 96) && (frame_start === 1'b1)) fs_early++;
      n_checks++;
      if ({vga_hs, vga_vs} !== {exp_hs, exp_vs}) begin
        n_fail++;
        $display("FAIL sync_track o=%0d: got hs=%b vs=%b expected hs=%b vs=%b",
                 o, vga_hs, vga_vs, exp_hs, exp_vs);
      end
    end
    n_checks++;
    if ((frame_start !== 1'b1) || (fs_early != 0)) begin
      n_fail++;
      $display("FAIL frame_period: got fs=%b at 96 with %0d early pulses, expected fs=1 and 0 early",
               frame_start, fs_early);
    end
    n_checks++;
    if ((hs_lo != 24) || (first_hs != 12)) begin
      n_fail++;
      $display("FAIL hs_timing: got %0d low clk first at %0d, expected 24 first at 12", hs_lo, first_hs);
    end
    n_checks++;
    if ((vs_lo != 16) || (first_vs != 66)) begin
      n_fail++;
      $display("FAIL vs_timing: got %0d low clk first at %0d, expected 16 first at 66", vs_lo, first_vs);
    end
  endtask

  task automatic test_late_request();
    int   acks = 0;
    logic found = 1'b0;
    logic bank_before;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_swap_pt) found = 1'b1;
    end
    step();
    swap_req = 1'b1;
    bank_before = m_bank;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_swap_pt) found = 1'b1;
      else if (swap_ack === 1'b1) acks++;
      else if (front_bank !== bank_before) acks++;
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL late_early_toggle: got %0d early ack/toggle cycles expected 0", acks);
    end
    n_checks++;
    if (!found || ({swap_ack, front_bank} !== {1'b1, ~bank_before})) begin
      n_fail++;
      $display("FAIL late_swap_point: got ack=%b bank=%b expected ack=1 bank=%b",
               swap_ack, front_bank, ~bank_before);
    end
    step();
    n_checks++;
    if (swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack_pulse: got ack=%b one clk later expected 0", swap_ack);
    end
    swap_req = 1'b0;
  endtask

  task automatic test_midline_reset();
    logic found = 1'b0;
    swap_req = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_swap_pt) found = 1'b1;
    end
    swap_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_fs) found = 1'b1;
    end
    repeat (20) step();
    n_checks++;
    if (front_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_bank: got %b expected 1", front_bank);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({rd_en, rd_addr, swap_ack, frame_start, front_bank} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_ctrl: got en=%b addr=%h ack=%b fs=%b bank=%b, expected all 0",
               rd_en, rd_addr, swap_ack, frame_start, front_bank);
    end
    n_checks++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {12'h000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset_video: got rgb=%h%h%h hs=%b vs=%b, expected rgb=000 hs=1 vs=1",
               vga_r, vga_g, vga_b, vga_hs, vga_vs);
    end
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_restart_idle: got en=%b expected 0", rd_en);
    end
    step();
    n_checks++;
    if ({rd_en, rd_addr, frame_start, front_bank} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_restart_fetch: got en=%b addr=%h fs=%b bank=%b expected en=1 addr=00 fs=1 bank=0",
               rd_en, rd_addr, frame_start, front_bank);
    end
    repeat (12) begin
      step();
      n_checks++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {exp_r, exp_g, exp_b, exp_hs, exp_vs}) begin
        n_fail++;
        $display("FAIL mid_restart_video e=%0d: got rgb=%h%h%h expected rgb=%h%h%h",
                 e, vga_r, vga_g, vga_b, exp_r, exp_g, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pixel_map();
    test_swap();
    test_sync();
    test_late_request();
    test_midline_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
